// File: rtl/reorder_buffer_param.sv
// Parametrised reorder buffer: in-order allocate/retire, tail walk-back flush on mispredict.
// Optional ROB_STATS_EN builds 32-bit retire/flush counters; otherwise those ports read 0.
module reorder_buffer_param #(
  parameter int unsigned Depth = 16,
  parameter int unsigned PrW   = 6,
  parameter int unsigned ArW   = 5,
  parameter int unsigned AddrW = 32,
  localparam int unsigned Rw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             is_dispatch_i,
  input  logic             mem_op_i,
  input  logic             reg_dest_i,
  input  logic [PrW-1:0]   pr_old_dp_i,
  input  logic [PrW-1:0]   pr_new_dp_i,
  input  logic [ArW-1:0]   rd_dp_i,
  input  logic             hazard_stall_i,
  input  logic             complete_i,
  input  logic [Rw-1:0]    rob_number_i,
  input  logic             change_flow_i,
  input  logic [AddrW-1:0] jb_addr_i,
  output logic             cmp_stall_o,
  output logic [Rw-1:0]    out_rob_num_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             retire_valid_o,
  output logic             reg_dest_retire_o,
  output logic             retire_lwst_o,
  output logic [PrW-1:0]   pr_old_rt_o,
  output logic [Rw-1:0]    retire_rob_o,
  output logic             recover_o,
  output logic             flush_valid_o,
  output logic             reg_dest_out_o,
  output logic [PrW-1:0]   pr_old_flush_o,
  output logic [PrW-1:0]   pr_new_flush_o,
  output logic [ArW-1:0]   rd_flush_o,
  output logic             change_flow_o,
  output logic [AddrW-1:0] change_flow_addr_o,
  output logic [31:0]      stat_retired_o,
  output logic [31:0]      stat_flushed_o
);

  typedef enum logic [1:0] {StIdle, StWalk, StRedir} state_e;

  localparam logic [Rw:0] FullCnt = (Rw + 1)'(Depth);
  localparam logic [Rw:0] PtrOne  = (Rw + 1)'(1);

  state_e             state_q, state_d;
  logic [Rw:0]        head_q, head_d, tail_q, tail_d, tail_m1, count;
  logic [Rw-1:0]      head_idx, tail_idx, tail_m1_idx, branch_rob_q, branch_rob_d;
  logic [Depth-1:0]   cmpl_q, cmpl_d, reg_dest_q, mem_op_q;
  logic [ArW-1:0]     rd_q     [Depth];
  logic [PrW-1:0]     pr_old_q [Depth];
  logic [PrW-1:0]     pr_new_q [Depth];
  logic [AddrW-1:0]   cf_addr_q;
  logic               wr_en, rd_en, accept, flush_valid;
  logic               ret_valid_q, ret_reg_dest_q, ret_mem_op_q;
  logic [PrW-1:0]     ret_pr_old_q;
  logic [Rw-1:0]      ret_rob_q;

  // Wrap bit in the pointer MSB separates full from empty.
  assign count       = tail_q - head_q;
  assign tail_m1     = tail_q - PtrOne;
  assign head_idx    = head_q[Rw-1:0];
  assign tail_idx    = tail_q[Rw-1:0];
  assign tail_m1_idx = tail_m1[Rw-1:0];
  assign full_o      = (count == FullCnt);
  assign empty_o     = (count == '0);

  assign accept = complete_i & change_flow_i & (state_q == StIdle);
  assign wr_en  = is_dispatch_i & ~full_o & ~hazard_stall_i & (state_q == StIdle) &
                  ~(complete_i & change_flow_i);
  assign rd_en  = cmpl_q[head_idx] & ~empty_o & ~hazard_stall_i & (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    branch_rob_d = branch_rob_q;
    flush_valid  = 1'b0;
    tail_d       = wr_en ? tail_q + PtrOne : tail_q;
    head_d       = rd_en ? head_q + PtrOne : head_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          branch_rob_d = rob_number_i;
          state_d      = (rob_number_i == tail_m1_idx) ? StRedir : StWalk;
        end
      end
      StWalk: begin
        if (tail_m1_idx != branch_rob_q) begin
          flush_valid = 1'b1;
          tail_d      = tail_m1;
        end else begin
          state_d = StRedir;
        end
      end
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reallocation clears the bit last so a stale completion cannot mark a fresh entry.
  always_comb begin
    cmpl_d = cmpl_q;
    if (complete_i) cmpl_d[rob_number_i] = 1'b1;
    if (wr_en)      cmpl_d[tail_idx]     = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      head_q         <= '0;
      tail_q         <= '0;
      cmpl_q         <= '0;
      branch_rob_q   <= '0;
      cf_addr_q      <= '0;
      ret_valid_q    <= 1'b0;
      ret_reg_dest_q <= 1'b0;
      ret_mem_op_q   <= 1'b0;
      ret_pr_old_q   <= '0;
      ret_rob_q      <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cmpl_q       <= cmpl_d;
      branch_rob_q <= branch_rob_d;
      ret_valid_q  <= rd_en;
      if (accept) cf_addr_q <= jb_addr_i;
      if (rd_en) begin
        ret_reg_dest_q <= reg_dest_q[head_idx];
        ret_mem_op_q   <= mem_op_q[head_idx];
        ret_pr_old_q   <= pr_old_q[head_idx];
        ret_rob_q      <= head_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      reg_dest_q[tail_idx] <= reg_dest_i;
      mem_op_q[tail_idx]   <= mem_op_i;
      rd_q[tail_idx]       <= rd_dp_i;
      pr_old_q[tail_idx]   <= pr_old_dp_i;
      pr_new_q[tail_idx]   <= pr_new_dp_i;
    end
  end

  assign cmp_stall_o        = (state_q != StIdle);
  assign recover_o          = (state_q == StWalk);
  assign change_flow_o      = (state_q == StRedir);
  assign change_flow_addr_o = cf_addr_q;
  assign out_rob_num_o      = tail_idx;
  assign flush_valid_o      = flush_valid;
  assign reg_dest_out_o     = reg_dest_q[tail_m1_idx];
  assign pr_old_flush_o     = pr_old_q[tail_m1_idx];
  assign pr_new_flush_o     = pr_new_q[tail_m1_idx];
  assign rd_flush_o         = rd_q[tail_m1_idx];
  assign retire_valid_o     = ret_valid_q;
  assign reg_dest_retire_o  = ret_reg_dest_q;
  assign retire_lwst_o      = ret_mem_op_q;
  assign pr_old_rt_o        = ret_pr_old_q;
  assign retire_rob_o       = ret_rob_q;

`ifdef ROB_STATS_EN
  logic [31:0] stat_ret_q, stat_fl_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_ret_q <= '0;
      stat_fl_q  <= '0;
    end else begin
      if (rd_en)       stat_ret_q <= stat_ret_q + 32'd1;
      if (flush_valid) stat_fl_q  <= stat_fl_q + 32'd1;
    end
  end
  assign stat_retired_o = stat_ret_q;
  assign stat_flushed_o = stat_fl_q;
`else
  assign stat_retired_o = '0;
  assign stat_flushed_o = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer_param.sv
// Scoreboard bench for reorder_buffer_param (Depth 16): dispatch model feeds expected retire,
// flush and redirect queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_reorder_buffer_param;

  typedef struct {
    logic [3:0] idx;
    logic [5:0] pr_old;
    logic [5:0] pr_new;
    logic [4:0] rd;
    logic       rdst;
    logic       mop;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        is_dispatch_i, mem_op_i, reg_dest_i, hazard_stall_i, complete_i, change_flow_i;
  logic [5:0]  pr_old_dp_i, pr_new_dp_i;
  logic [4:0]  rd_dp_i;
  logic [3:0]  rob_number_i;
  logic [31:0] jb_addr_i;
  logic        cmp_stall_o, full_o, empty_o, retire_valid_o, reg_dest_retire_o, retire_lwst_o;
  logic [3:0]  out_rob_num_o, retire_rob_o;
  logic [5:0]  pr_old_rt_o, pr_old_flush_o, pr_new_flush_o;
  logic        recover_o, flush_valid_o, reg_dest_out_o, change_flow_o;
  logic [4:0]  rd_flush_o;
  logic [31:0] change_flow_addr_o, stat_retired_o, stat_flushed_o;

  int tests = 0;
  int fails = 0;
  int n_disp = 0;
  logic [4:0] model_tail = '0;
  ent_t exp_ret[$];
  ent_t exp_fl[$];
  logic [31:0] exp_redir[$];
  ent_t m_e;
  logic [3:0] m_fi;

  reorder_buffer_param #(.Depth(16), .PrW(6), .ArW(5), .AddrW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .is_dispatch_i(is_dispatch_i), .mem_op_i(mem_op_i), .reg_dest_i(reg_dest_i),
    .pr_old_dp_i(pr_old_dp_i), .pr_new_dp_i(pr_new_dp_i), .rd_dp_i(rd_dp_i),
    .hazard_stall_i(hazard_stall_i), .complete_i(complete_i), .rob_number_i(rob_number_i),
    .change_flow_i(change_flow_i), .jb_addr_i(jb_addr_i),
    .cmp_stall_o(cmp_stall_o), .out_rob_num_o(out_rob_num_o), .full_o(full_o),
    .empty_o(empty_o), .retire_valid_o(retire_valid_o), .reg_dest_retire_o(reg_dest_retire_o),
    .retire_lwst_o(retire_lwst_o), .pr_old_rt_o(pr_old_rt_o), .retire_rob_o(retire_rob_o),
    .recover_o(recover_o), .flush_valid_o(flush_valid_o), .reg_dest_out_o(reg_dest_out_o),
    .pr_old_flush_o(pr_old_flush_o), .pr_new_flush_o(pr_new_flush_o),
    .rd_flush_o(rd_flush_o), .change_flow_o(change_flow_o),
    .change_flow_addr_o(change_flow_addr_o), .stat_retired_o(stat_retired_o),
    .stat_flushed_o(stat_flushed_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected pulse, required none", nm);
  endtask

  // Monitor: pops a scoreboard entry for each output event the DUT presents.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (retire_valid_o) begin
        if (exp_ret.size() == 0) unexpected("retire");
        else begin
          m_e = exp_ret.pop_front();
          chk("retire_rob", retire_rob_o, m_e.idx);
          chk("pr_old_rt", pr_old_rt_o, m_e.pr_old);
          chk("reg_dest_retire", reg_dest_retire_o, m_e.rdst);
          chk("retire_lwst", retire_lwst_o, m_e.mop);
        end
      end
      if (flush_valid_o) begin
        if (exp_fl.size() == 0) unexpected("flush");
        else begin
          m_e  = exp_fl.pop_front();
          m_fi = out_rob_num_o - 4'd1;
          chk("flush_idx", m_fi, m_e.idx);
          chk("pr_old_flush", pr_old_flush_o, m_e.pr_old);
          chk("pr_new_flush", pr_new_flush_o, m_e.pr_new);
          chk("rd_flush", rd_flush_o, m_e.rd);
          chk("reg_dest_out", reg_dest_out_o, m_e.rdst);
        end
      end
      if (change_flow_o) begin
        if (exp_redir.size() == 0) unexpected("redirect");
        else chk("change_flow_addr", change_flow_addr_o, exp_redir.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic dispatch();
    ent_t e;
    e.idx    = model_tail[3:0];
    e.pr_old = 6'(n_disp * 3 + 1);
    e.pr_new = 6'(n_disp * 5 + 2);
    e.rd     = 5'(n_disp + 7);
    e.rdst   = (n_disp % 4) != 3;
    e.mop    = (n_disp % 3) == 0;
    is_dispatch_i = 1'b1;
    pr_old_dp_i = e.pr_old;
    pr_new_dp_i = e.pr_new;
    rd_dp_i = e.rd;
    reg_dest_i = e.rdst;
    mem_op_i = e.mop;
    exp_ret.push_back(e);
    model_tail++;
    n_disp++;
    tick();
    is_dispatch_i = 1'b0;
  endtask

  task automatic complete_rob(input int r);
    complete_i = 1'b1;
    rob_number_i = 4'(r);
    tick();
    complete_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (!empty_o && n < 40) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(nm, empty_o, 1'b1);
    chk({nm, "_sb"}, exp_ret.size(), 0);
  endtask

  task automatic mispredict(input int br, input int k, input logic [31:0] addr);
    int cyc = 0;
    int nfl = 0;
    for (int i = 0; i < k; i++) exp_fl.push_back(exp_ret.pop_back());
    exp_redir.push_back(addr);
    complete_i = 1'b1;
    change_flow_i = 1'b1;
    rob_number_i = 4'(br);
    jb_addr_i = addr;
    tick();
    complete_i = 1'b0;
    change_flow_i = 1'b0;
    jb_addr_i = '0;
    while (!change_flow_o && cyc < 20) begin
      chk("walk_cmp_stall", cmp_stall_o, 1'b1);
      chk("walk_recover", recover_o, 1'b1);
      if (flush_valid_o) nfl++;
      tick();
      cyc++;
    end
    chk("redirect_seen", change_flow_o, 1'b1);
    chk("redir_cmp_stall", cmp_stall_o, 1'b1);
    chk("walk_cycles", cyc, k == 0 ? 0 : k + 1);
    chk("flush_count", nfl, k);
    model_tail = model_tail - 5'(k);
    tick();
    chk("post_redir_stall", cmp_stall_o, 1'b0);
    chk("post_redir_pulse", change_flow_o, 1'b0);
    chk("post_redir_tail", out_rob_num_o, model_tail[3:0]);
  endtask

  initial begin
    rst_ni = 1'b0;
    {is_dispatch_i, mem_op_i, reg_dest_i, hazard_stall_i, complete_i, change_flow_i} = '0;
    pr_old_dp_i = '0; pr_new_dp_i = '0; rd_dp_i = '0; rob_number_i = '0; jb_addr_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();

    // Reset state
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_tail", out_rob_num_o, 4'd0);
    chk("rst_retire_valid", retire_valid_o, 1'b0);
    chk("rst_pr_old_rt", pr_old_rt_o, 6'd0);
    chk("rst_cmp_stall", cmp_stall_o, 1'b0);
    chk("rst_recover", recover_o, 1'b0);
    chk("rst_cf_addr", change_flow_addr_o, 32'd0);

    // Fill to Depth; 17th dispatch is dropped
    for (int i = 0; i < 15; i++) dispatch();
    chk("fill15_full", full_o, 1'b0);
    dispatch();
    chk("fill16_full", full_o, 1'b1);
    chk("fill16_tail", out_rob_num_o, 4'd0);
    is_dispatch_i = 1'b1;
    tick();
    is_dispatch_i = 1'b0;
    chk("overflow_tail", out_rob_num_o, 4'd0);
    chk("overflow_full", full_o, 1'b1);
    for (int i = 0; i < 16; i++) complete_rob(i);
    drain("fill_drain");

    // Out-of-order completion, in-order retire on consecutive cycles
    for (int i = 0; i < 3; i++) dispatch();
    complete_rob(1);
    complete_rob(0);
    chk("ooo_rv0", retire_valid_o, 1'b0);
    tick();
    chk("ooo_rv1", retire_valid_o, 1'b1);
    chk("ooo_idx1", retire_rob_o, 4'd0);
    tick();
    chk("ooo_rv2", retire_valid_o, 1'b1);
    chk("ooo_idx2", retire_rob_o, 4'd1);
    tick();
    chk("ooo_rv3", retire_valid_o, 1'b0);
    chk("ooo_held", empty_o, 1'b0);
    complete_rob(2);
    drain("ooo_drain");

    // Fresh reset, then walk of 3 younger entries
    @(negedge clk_i) rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    model_tail = '0;
    tick();
    for (int i = 0; i < 6; i++) dispatch();
    mispredict(2, 3, 32'h400);
    chk("walk_tail3", out_rob_num_o, 4'd3);
    complete_rob(0);
    complete_rob(1);
    drain("walk_drain");

    // Zero-length walk: branch is the youngest entry
    dispatch();
    mispredict(3, 0, 32'h123);
    drain("zero_drain");

    // Wrap: head/tail at 14, branch 14 with younger 15,0,1
    for (int i = 0; i < 10; i++) dispatch();
    for (int i = 4; i < 14; i++) complete_rob(i);
    drain("wrap_pre_drain");
    for (int i = 0; i < 4; i++) dispatch();
    mispredict(14, 3, 32'hBEEF0);
    chk("wrap_tail15", out_rob_num_o, 4'd15);
    drain("wrap_drain");

    // hazard_stall blocks both retire and allocate
    dispatch();
    hazard_stall_i = 1'b1;
    complete_rob(15);
    is_dispatch_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hz_retire", retire_valid_o, 1'b0);
      chk("hz_tail", out_rob_num_o, 4'd0);
      chk("hz_empty", empty_o, 1'b0);
    end
    is_dispatch_i = 1'b0;
    hazard_stall_i = 1'b0;
    drain("hz_drain");

    // Reset during a walk aborts straight to reset values
    for (int i = 0; i < 4; i++) dispatch();
    complete_i = 1'b1;
    change_flow_i = 1'b1;
    rob_number_i = 4'd0;
    jb_addr_i = 32'h77;
    tick();
    complete_i = 1'b0;
    change_flow_i = 1'b0;
    chk("abort_recover_pre", recover_o, 1'b1);
    rst_ni = 1'b0;
    exp_ret.delete();
    #1;
    chk("abort_recover", recover_o, 1'b0);
    chk("abort_flush", flush_valid_o, 1'b0);
    chk("abort_stall", cmp_stall_o, 1'b0);
    chk("abort_empty", empty_o, 1'b1);
    chk("abort_cf_addr", change_flow_addr_o, 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    tick();
    chk("end_fl_sb", exp_fl.size(), 0);
    chk("end_redir_sb", exp_redir.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
